// File: rtl/ri_exec_pipe.sv
// ri_exec_pipe: two-stage issue/execute register-immediate pipeline with EX->issue bypass.
module ri_exec_pipe #(
  parameter int N = 32,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  instruction,
  input  logic [3:0]   alu_op,
  input  logic         reg_write,
  input  logic         alu_src,
  input  logic         xo,
  input  logic         hold,
  input  logic [4:0]   dbg_addr,
  output logic [N-1:0] dbg_data,
  output logic         wb_valid,
  output logic         wb_we,
  output logic [4:0]   wb_reg,
  output logic [N-1:0] wb_data,
  output logic         wb_zero,
  output logic         wb_carry,
  output logic         wb_ovf
);
  localparam int LW = (NREGS > 1) ? $clog2(NREGS) : 1;
  logic [N-1:0] regs [NREGS];
  logic         ex_valid, ex_we;
  logic [4:0]   ex_dest;
  logic [3:0]   ex_op;
  logic [N-1:0] ex_a, ex_b;
  logic [4:0]   ra, rb, rd;
  logic [N-1:0] imm, op_a, op_b, alu_res;
  logic [N:0]   add_r, sub_r;
  logic         alu_carry, alu_ovf;
  logic         unused_ok;
  assign unused_ok = ^instruction[31:26];
  assign ra  = xo ? instruction[20:16] : instruction[25:21];
  assign rd  = xo ? instruction[25:21] : instruction[20:16];
  assign rb  = instruction[15:11];
  assign imm = N'(signed'(instruction[15:0]));
  // Forward the executing result to either issuing read port that names its destination.
  assign op_a = (ex_valid && ex_we && ex_dest[LW-1:0] == ra[LW-1:0]) ? alu_res : regs[ra[LW-1:0]];
  assign op_b = alu_src ? imm :
                (ex_valid && ex_we && ex_dest[LW-1:0] == rb[LW-1:0]) ? alu_res : regs[rb[LW-1:0]];
  assign dbg_data = regs[dbg_addr[LW-1:0]];
  assign add_r = {1'b0, ex_a} + {1'b0, ex_b};
  assign sub_r = {1'b0, ex_a} + {1'b0, ~ex_b} + (N+1)'(1);
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (ex_op)
      4'b0000: alu_res = ex_a & ex_b;
      4'b0001: alu_res = ex_a | ex_b;
      4'b0010: begin
        {alu_carry, alu_res} = add_r;
        alu_ovf = (ex_a[N-1] == ex_b[N-1]) && (add_r[N-1] != ex_a[N-1]);
      end
      4'b0110: begin
        {alu_carry, alu_res} = sub_r;
        alu_ovf = (ex_a[N-1] != ex_b[N-1]) && (sub_r[N-1] != ex_a[N-1]);
      end
      4'b0111: alu_res = N'($signed(ex_a) < $signed(ex_b));
      4'b1100: alu_res = ~(ex_a | ex_b);
      default: alu_res = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_we    <= 1'b0;
      ex_dest  <= '0;
      ex_op    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
      wb_zero  <= 1'b0;
      wb_carry <= 1'b0;
      wb_ovf   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (!hold) begin
      ex_valid <= in_valid;
      ex_we    <= in_valid & reg_write;
      ex_dest  <= rd;
      ex_op    <= alu_op;
      ex_a     <= op_a;
      ex_b     <= op_b;
      wb_valid <= ex_valid;
      wb_we    <= ex_valid & ex_we;
      if (ex_valid) begin
        wb_reg   <= ex_dest;
        wb_data  <= alu_res;
        wb_zero  <= (alu_res == '0);
        wb_carry <= alu_carry;
        wb_ovf   <= alu_ovf;
      end
      if (ex_valid && ex_we) regs[ex_dest[LW-1:0]] <= alu_res;
    end
  end
endmodule

// File: tb/tb_ri_exec_pipe.sv
// tb_ri_exec_pipe: directed-vector bench for ri_exec_pipe with hand-computed results.
module tb_ri_exec_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic [3:0]  alu_op = '0;
  logic        reg_write = 1'b0, alu_src = 1'b0, xo = 1'b0, hold = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data, wb_data;
  logic        wb_valid, wb_we, wb_zero, wb_carry, wb_ovf;
  logic [4:0]  wb_reg;
  int vectors = 0;
  int miscompares = 0;

  ri_exec_pipe #(.N(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
    .alu_op(alu_op), .reg_write(reg_write), .alu_src(alu_src), .xo(xo),
    .hold(hold), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_zero(wb_zero), .wb_carry(wb_carry), .wb_ovf(wb_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic [3:0]  op;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        z, c, o;
  } vec_t;

  function automatic logic [31:0] enc(input logic [4:0] f25, input logic [4:0] f20, input logic [15:0] low);
    return {6'b0, f25, f20, low};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [31:0] ins, input logic [3:0] op,
                       input logic we, input logic src, input logic x);
    in_valid = v; instruction = ins; alu_op = op; reg_write = we; alu_src = src; xo = x;
  endtask

  task automatic idle();
    issue(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      vectors++;
      if (dbg_data !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_dbg r%0d got %h want 0", i, dbg_data);
      end
    end
    vectors++;
    if ({wb_valid, wb_we, wb_zero, wb_carry, wb_ovf, wb_reg, wb_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_wb got v%b we%b z%b c%b o%b r%0d d%h want all 0",
               wb_valid, wb_we, wb_zero, wb_carry, wb_ovf, wb_reg, wb_data);
    end
  endtask

  task automatic test_bypass();
    issue(1'b1, enc(5'd17, 5'd0, 16'd20), 4'b0010, 1'b1, 1'b1, 1'b1);
    step();
    issue(1'b1, enc(5'd19, 5'd17, {5'd17, 11'b0}), 4'b0010, 1'b1, 1'b0, 1'b1);
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd17 || wb_data !== 32'd20) begin
      miscompares++;
      $display("FAIL bypass_addi got v%b r%0d d%0d want v1 r17 d20", wb_valid, wb_reg, wb_data);
    end
    idle();
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd19 || wb_data !== 32'd40) begin
      miscompares++;
      $display("FAIL bypass_add got v%b r%0d d%0d want v1 r19 d40", wb_valid, wb_reg, wb_data);
    end
    step();
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble_valid got %b want 0", wb_valid);
    end
    dbg_addr = 5'd19;
    #1;
    vectors++;
    if (dbg_data !== 32'd40) begin
      miscompares++;
      $display("FAIL bypass_r19 got %0d want 40", dbg_data);
    end
  endtask

  task automatic test_sub_ovf();
    issue(1'b1, enc(5'd1, 5'd0, 16'h4000), 4'b0010, 1'b1, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 17; i++) begin
      issue(1'b1, enc(5'd1, 5'd1, {5'd1, 11'b0}), 4'b0010, 1'b1, 1'b0, 1'b1);
      step();
    end
    issue(1'b1, enc(5'd2, 5'd1, 16'd1), 4'b0110, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    step();
    vectors++;
    if (wb_data !== 32'h7FFF_FFFF || wb_ovf !== 1'b1 || wb_carry !== 1'b1 || wb_zero !== 1'b0 || wb_reg !== 5'd2) begin
      miscompares++;
      $display("FAIL sub_ovf got d%h o%b c%b z%b r%0d want d7fffffff o1 c1 z0 r2",
               wb_data, wb_ovf, wb_carry, wb_zero, wb_reg);
    end
    dbg_addr = 5'd1;
    #1;
    vectors++;
    if (dbg_data !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL preload_r1 got %h want 80000000", dbg_data);
    end
  endtask

  task automatic test_alu_ops();
    vec_t v[8];
    v[0] = '{enc(5'd1,  5'd3,  {5'd17, 11'b0}), 4'b0111, 1'b1, 5'd3,  32'd1,          1'b0, 1'b0, 1'b0};
    v[1] = '{enc(5'd17, 5'd4,  {5'd1,  11'b0}), 4'b0111, 1'b1, 5'd4,  32'd0,          1'b1, 1'b0, 1'b0};
    v[2] = '{enc(5'd19, 5'd5,  {5'd17, 11'b0}), 4'b0000, 1'b1, 5'd5,  32'd0,          1'b1, 1'b0, 1'b0};
    v[3] = '{enc(5'd19, 5'd6,  {5'd17, 11'b0}), 4'b0001, 1'b1, 5'd6,  32'd60,         1'b0, 1'b0, 1'b0};
    v[4] = '{enc(5'd19, 5'd7,  {5'd17, 11'b0}), 4'b1100, 1'b1, 5'd7,  32'hFFFF_FFC3,  1'b0, 1'b0, 1'b0};
    v[5] = '{enc(5'd1,  5'd8,  {5'd1,  11'b0}), 4'b0010, 1'b1, 5'd8,  32'd0,          1'b1, 1'b1, 1'b1};
    v[6] = '{enc(5'd17, 5'd9,  {5'd19, 11'b0}), 4'b0110, 1'b1, 5'd9,  32'hFFFF_FFEC,  1'b0, 1'b0, 1'b0};
    v[7] = '{enc(5'd19, 5'd12, {5'd17, 11'b0}), 4'b0011, 1'b0, 5'd12, 32'd0,          1'b1, 1'b0, 1'b0};
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) issue(1'b1, v[i].ins, v[i].op, v[i].we, 1'b0, 1'b0);
      else idle();
      step();
      if (i >= 1) begin
        vectors++;
        if (wb_valid !== 1'b1 || wb_we !== v[i-1].we || wb_reg !== v[i-1].rd || wb_data !== v[i-1].d ||
            wb_zero !== v[i-1].z || wb_carry !== v[i-1].c || wb_ovf !== v[i-1].o) begin
          miscompares++;
          $display("FAIL alu_op%0d got v%b we%b r%0d d%h z%b c%b o%b want v1 we%b r%0d d%h z%b c%b o%b",
                   i-1, wb_valid, wb_we, wb_reg, wb_data, wb_zero, wb_carry, wb_ovf,
                   v[i-1].we, v[i-1].rd, v[i-1].d, v[i-1].z, v[i-1].c, v[i-1].o);
        end
      end
    end
  endtask

  task automatic test_xo0();
    issue(1'b1, enc(5'd6, 5'd22, 16'h0), 4'b0000, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_reg !== 5'd22 || wb_data !== 32'd0 || wb_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL xo0_andi got v%b we%b r%0d d%h z%b want v1 we1 r22 d0 z1",
               wb_valid, wb_we, wb_reg, wb_data, wb_zero);
    end
    issue(1'b1, enc(5'd0, 5'd0, 16'd5), 4'b0010, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    step();
    dbg_addr = 5'd0;
    #1;
    vectors++;
    if (dbg_data !== 32'd5) begin
      miscompares++;
      $display("FAIL r0_write got %0d want 5", dbg_data);
    end
  endtask

  task automatic test_hold();
    idle();
    step(); step();
    issue(1'b1, enc(5'd10, 5'd17, {5'd19, 11'b0}), 4'b0010, 1'b1, 1'b0, 1'b1);
    step();
    hold = 1'b1;
    issue(1'b1, enc(5'd11, 5'd0, 16'd99), 4'b0010, 1'b1, 1'b1, 1'b1);
    dbg_addr = 5'd10;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (wb_valid !== 1'b0 || dbg_data !== 32'd0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d got v%b r10=%0d want v0 r10=0", i, wb_valid, dbg_data);
      end
    end
    hold = 1'b0;
    idle();
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd10 || wb_data !== 32'd60 || dbg_data !== 32'd60) begin
      miscompares++;
      $display("FAIL hold_release got v%b r%0d d%0d r10=%0d want v1 r10 d60 r10=60",
               wb_valid, wb_reg, wb_data, dbg_data);
    end
    step();
    dbg_addr = 5'd11;
    #1;
    vectors++;
    if (wb_valid !== 1'b0 || dbg_data !== 32'd0) begin
      miscompares++;
      $display("FAIL hold_ignored got v%b r11=%0d want v0 r11=0", wb_valid, dbg_data);
    end
  endtask

  task automatic test_reset_mid();
    dbg_addr = 5'd17;
    issue(1'b1, enc(5'd11, 5'd0, 16'd9), 4'b0010, 1'b1, 1'b1, 1'b1);
    step();
    issue(1'b1, enc(5'd12, 5'd0, 16'd3), 4'b0010, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dbg_data !== 32'd0 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got r17=%0d v%b want 0 0", dbg_data, wb_valid);
    end
    step();
    rst = 1'b0;
    idle();
    step(); step();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      vectors++;
      if (dbg_data !== 32'h0) begin
        miscompares++;
        $display("FAIL midreset_dbg r%0d got %h want 0", i, dbg_data);
      end
    end
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_wb got v%b want 0", wb_valid);
    end
    rst = 1'b1;
    step();
    #2 rst = 1'b0;
    issue(1'b1, enc(5'd13, 5'd0, 16'd7), 4'b0010, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd13 || wb_data !== 32'd7) begin
      miscompares++;
      $display("FAIL first_after_reset got v%b r%0d d%0d want v1 r13 d7", wb_valid, wb_reg, wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_sub_ovf();
    test_alu_ops();
    test_xo0();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
